// File: rtl/trigger_chain_capture_x8_pkg.sv
// rtl/trigger_chain_capture_x8_pkg.sv - shared types and register layout for the trigger chain capture buffer
package trigger_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int CTRL_START     = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int CTRL_WAIT_TRIG = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_TIMED_OUT = 2;
    localparam int STAT_WAIT_TRIG = 3;
    localparam int STAT_COUNT_LSB = 16;

    // The register window sits above the buffer: select bit = DEPTH_BITS + REG_SEL_OFFSET
    localparam int REG_SEL_OFFSET = 6;

    typedef logic [39:0]     sample_t;
    typedef sample_t [7:0]   beat_t;

endpackage

// File: rtl/trigger_chain_capture_x8_if.sv
// rtl/trigger_chain_capture_x8_if.sv - Wishbone classic target bundle for the capture buffer
interface trigger_chain_capture_x8_if #(
    parameter int DEPTH_BITS = 8
);
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [DEPTH_BITS+6:0] wb_adr_i;
    logic [31:0]           wb_dat_i;
    logic [3:0]            wb_sel_i;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_o;
    logic                  wb_err_o;
    logic                  wb_rty_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/trigger_chain_capture_x8_capture_ram.sv
// rtl/trigger_chain_capture_x8_capture_ram.sv - simple dual-port capture RAM with registered read
module capture_ram #(
    parameter int ADDR_BITS = 8,
    parameter int WIDTH     = 320
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/trigger_chain_capture_x8.sv
// rtl/trigger_chain_capture_x8.sv - captures a window of 8-channel trigger chain beats, readable over Wishbone
module trigger_chain_capture_x8
    import trigger_capture_pkg::*;
#(
    parameter int          DEPTH_BITS   = 8,
    parameter logic [31:0] TRIG_TIMEOUT = 32'hFFFF_FFFF
) (
    input  logic  aclk,
    input  logic  aresetn,
    input  beat_t dat_i,
    input  logic  trig_i,
    trigger_chain_capture_x8_if.slave wb,
    output logic  busy_o
);
    localparam int N = DEPTH_BITS + REG_SEL_OFFSET;

    state_t                state, state_nx;
    logic [DEPTH_BITS:0]   count;
    logic [31:0]           tcnt;
    logic                  timed_out, wait_trig;
    logic                  hold, rd_pend, rd_hi;
    logic [2:0]            rd_ch;
    logic [8*40-1:0]       ram_rdata;
    beat_t                 rd_beat;
    sample_t               rd_sample;
    logic [31:0]           rd_word, status;

    logic req, accept, is_reg, buf_live;
    logic acc_reg, acc_rd, acc_err, ctrl_wr, start, abort, go, cap_we, last_beat, timeout_hit;

    assign req      = wb.wb_cyc_i & wb.wb_stb_i;
    assign accept   = req & ~hold;
    assign is_reg   = wb.wb_adr_i[N];
    assign buf_live = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign acc_reg  = accept & is_reg & ~wb.wb_adr_i[2];
    assign acc_rd   = accept & ~is_reg & ~wb.wb_we_i & ~buf_live;
    assign acc_err  = accept & ~acc_reg & ~acc_rd;
    assign ctrl_wr  = acc_reg & wb.wb_we_i & wb.wb_sel_i[0];
    assign start    = ctrl_wr & wb.wb_dat_i[CTRL_START];
    assign abort    = ctrl_wr & wb.wb_dat_i[CTRL_ABORT];
    assign go       = start & ~abort & ((state == ST_IDLE) || (state == ST_DONE));
    assign cap_we   = (state == ST_CAPTURE) & ~abort;
    assign last_beat   = &count[DEPTH_BITS-1:0];
    // All-ones timeout never fires, so ARMED waits forever for a trigger
    assign timeout_hit = (TRIG_TIMEOUT != 32'hFFFF_FFFF) && (tcnt == TRIG_TIMEOUT - 32'd1);
    assign wb.wb_rty_o = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{wb.wb_dat_i[31:3], wb.wb_sel_i[3:1], wb.wb_adr_i[1:0]};

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (abort)      state_nx = ST_IDLE;
                else if (start) state_nx = wb.wb_dat_i[CTRL_WAIT_TRIG] ? ST_ARMED : ST_CAPTURE;
            end
            ST_ARMED: begin
                if (abort)            state_nx = ST_IDLE;
                else if (trig_i)      state_nx = ST_CAPTURE;
                else if (timeout_hit) state_nx = ST_IDLE;
            end
            ST_CAPTURE: begin
                if (abort)          state_nx = ST_IDLE;
                else if (last_beat) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            busy_o    <= 1'b0;
            count     <= '0;
            tcnt      <= '0;
            timed_out <= 1'b0;
            wait_trig <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_o <= buf_live;
            if (ctrl_wr) begin
                wait_trig <= wb.wb_dat_i[CTRL_WAIT_TRIG];
            end
            if (go) begin
                count     <= '0;
                tcnt      <= '0;
                timed_out <= 1'b0;
            end else begin
                if (cap_we)              count <= count + 1'b1;
                if (state == ST_ARMED)   tcnt  <= tcnt + 32'd1;
                if ((state == ST_ARMED) && !abort && !trig_i && timeout_hit) timed_out <= 1'b1;
            end
        end
    end

    always_comb begin
        status                 = '0;
        status[STAT_BUSY]      = buf_live;
        status[STAT_DONE]      = (state == ST_DONE);
        status[STAT_TIMED_OUT] = timed_out;
        status[STAT_WAIT_TRIG] = wait_trig;
        status[31:STAT_COUNT_LSB] = 16'(count);
    end

    capture_ram #(
        .ADDR_BITS (DEPTH_BITS),
        .WIDTH     (8*40)
    ) u_ram (
        .clk   (aclk),
        .we    (cap_we),
        .waddr (count[DEPTH_BITS-1:0]),
        .wdata (dat_i),
        .re    (acc_rd),
        .raddr (wb.wb_adr_i[N-1:6]),
        .rdata (ram_rdata)
    );

    assign rd_beat   = ram_rdata;
    assign rd_sample = rd_beat[rd_ch];
    assign rd_word   = rd_hi ? {24'h0, rd_sample[39:32]} : rd_sample[31:0];

    // hold blocks a second termination until the master drops the strobe
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold        <= 1'b0;
            rd_pend     <= 1'b0;
            rd_ch       <= '0;
            rd_hi       <= 1'b0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            wb.wb_dat_o <= '0;
        end else begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            wb.wb_dat_o <= '0;
            if (accept)   hold <= 1'b1;
            else if (!req) hold <= 1'b0;
            rd_pend <= acc_rd;
            if (acc_rd) begin
                rd_ch <= wb.wb_adr_i[5:3];
                rd_hi <= wb.wb_adr_i[2];
            end
            if (acc_reg) begin
                wb.wb_ack_o <= 1'b1;
                if (!wb.wb_we_i) wb.wb_dat_o <= status;
            end
            if (acc_err) begin
                wb.wb_err_o <= 1'b1;
            end
            if (rd_pend && wb.wb_cyc_i) begin
                wb.wb_ack_o <= 1'b1;
                wb.wb_dat_o <= rd_word;
            end
        end
    end
endmodule

// File: tb/tb_trigger_chain_capture_x8.sv
// tb/tb_trigger_chain_capture_x8.sv - scoreboard bench for the trigger chain capture buffer
module tb_trigger_chain_capture_x8;
    import trigger_capture_pkg::*;

    localparam int DB = 8;
    localparam int AW = DB + 7;
    localparam logic [AW-1:0] REG_ADR  = 15'h4000;
    localparam logic [AW-1:0] REG_ADR4 = 15'h4004;

    logic  aclk = 1'b0;
    logic  aresetn = 1'b0;
    beat_t dat;
    logic  trig = 1'b0;
    logic  busy;

    trigger_chain_capture_x8_if #(.DEPTH_BITS(DB)) wb();

    trigger_chain_capture_x8 #(
        .DEPTH_BITS   (DB),
        .TRIG_TIMEOUT (32'd100)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .dat_i   (dat),
        .trig_i  (trig),
        .wb      (wb),
        .busy_o  (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          is_err;
        bit          chk_dat;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc_cnt = 0;
    int    issue_cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    exp_t  mon_e;
    string mon_nm;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ramp_lo(input int k);
        return 32'hC000_0000 + 32'(k);
    endfunction

    function automatic logic [AW-1:0] buf_adr(input int beat, input int ch, input bit w);
        return {1'b0, beat[7:0], ch[2:0], w, 2'b00};
    endfunction

    // Ramp source: each channel tagged with its index above a cycle-count low word
    initial begin
        for (int c = 0; c < 8; c++) dat[c] = '0;
        forever begin
            @(posedge aclk);
            cyc_cnt++;
            #1;
            for (int c = 0; c < 8; c++) dat[c] = {8'(c), ramp_lo(cyc_cnt)};
        end
    end

    always @(negedge aclk) begin
        if (aresetn && (wb.wb_ack_o || wb.wb_err_o)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_term: ack=%0b err=%0b expected no termination", wb.wb_ack_o, wb.wb_err_o);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                check({mon_nm, "_term"}, 32'({wb.wb_err_o, wb.wb_ack_o}), 32'({mon_e.is_err, !mon_e.is_err}));
                check({mon_nm, "_lat"}, 32'(cyc_cnt - issue_cyc), 32'(mon_e.lat));
                if (mon_e.chk_dat) check({mon_nm, "_dat"}, wb.wb_dat_o, mon_e.dat);
            end
        end
    end

    task automatic wb_xfer(input bit we, input logic [AW-1:0] adr, input logic [31:0] wd,
                           input logic [3:0] sel, input bit exp_err, input bit chk,
                           input logic [31:0] exp_dat, input int lat, input string nm,
                           output int acc);
        exp_t e;
        int   n;
        e.is_err = exp_err; e.chk_dat = chk; e.dat = exp_dat; e.lat = lat;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge aclk); #1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = adr; wb.wb_dat_i = wd; wb.wb_sel_i = sel;
        issue_cyc = cyc_cnt;
        acc = cyc_cnt + 1;
        n = 0;
        do begin
            @(posedge aclk); #1;
            n++;
        end while (!(wb.wb_ack_o || wb.wb_err_o) && n < 8);
        if (!(wb.wb_ack_o || wb.wb_err_o)) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: no termination after %0d cycles, required one", nm, n);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    endtask

    task automatic reg_wr(input logic [31:0] v, input string nm, output int acc);
        wb_xfer(1'b1, REG_ADR, v, 4'hF, 1'b0, 1'b0, 32'h0, 1, nm, acc);
    endtask

    task automatic reg_rd(input logic [31:0] exp, input string nm);
        int acc;
        wb_xfer(1'b0, REG_ADR, 32'h0, 4'hF, 1'b0, 1'b1, exp, 1, nm, acc);
    endtask

    task automatic buf_rd(input int beat, input int ch, input bit w, input logic [31:0] exp, input string nm);
        int acc;
        wb_xfer(1'b0, buf_adr(beat, ch, w), 32'h0, 4'hF, 1'b0, 1'b1, exp, 2, nm, acc);
    endtask

    task automatic bus_err(input bit we, input logic [AW-1:0] adr, input string nm);
        int acc;
        wb_xfer(we, adr, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 32'h0, 1, nm, acc);
    endtask

    task automatic wait_idle(input string nm, output int when);
        int n;
        n = 0;
        when = -1;
        while (n < 400 && when < 0) begin
            @(posedge aclk); #1;
            n++;
            if (!busy) when = cyc_cnt;
        end
        if (when < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_busy_timeout: busy still high after %0d cycles, required low", nm, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int s, t, when, acc, n_ack;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack",  32'(wb.wb_ack_o), 32'd0);
        check("rst_err",  32'(wb.wb_err_o), 32'd0);
        check("rst_rty",  32'(wb.wb_rty_o), 32'd0);
        check("rst_dat",  wb.wb_dat_o, 32'd0);
        aresetn = 1'b1;
        reg_rd(32'h0000_0000, "rst_status");

        // START with byte 0 disabled must not take effect
        wb_xfer(1'b1, REG_ADR, 32'h1, 4'b1110, 1'b0, 1'b0, 32'h0, 1, "sel_wr", acc);
        @(posedge aclk); #1;
        check("sel_ignored_busy", 32'(busy), 32'd0);

        // Free-running capture
        reg_wr(32'h1, "free_start", s);
        wait_idle("free", when);
        check("free_done_cycle", 32'(when), 32'(s + 257));
        reg_rd(32'h0100_0002, "free_status");
        buf_rd(17, 5, 1'b0, ramp_lo(s + 17), "free_b17c5w0");
        buf_rd(17, 5, 1'b1, 32'h0000_0005, "free_b17c5w1");
        buf_rd(0, 0, 1'b0, ramp_lo(s), "free_b0c0w0");
        buf_rd(255, 7, 1'b0, ramp_lo(s + 255), "free_b255c7w0");
        buf_rd(255, 7, 1'b1, 32'h0000_0007, "free_b255c7w1");

        // Dropping cyc after acceptance cancels the pending read ack
        @(posedge aclk); #1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = buf_adr(3, 3, 1'b0); wb.wb_sel_i = 4'hF;
        issue_cyc = cyc_cnt;
        @(posedge aclk); #1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        n_ack = 0;
        repeat (3) begin
            @(posedge aclk); #1;
            if (wb.wb_ack_o || wb.wb_err_o) n_ack++;
        end
        check("drop_cyc_no_ack", 32'(n_ack), 32'd0);

        // Triggered capture
        reg_wr(32'h5, "trig_start", s);
        reg_rd(32'h0000_0009, "trig_armed_status");
        repeat (39) @(posedge aclk);
        @(posedge aclk); #1;
        trig = 1'b1;
        t = cyc_cnt + 1;
        @(posedge aclk); #1;
        trig = 1'b0;
        reg_rd(32'h0001_0009, "trig_capture_status");
        wait_idle("trig", when);
        check("trig_done_cycle", 32'(when), 32'(t + 257));
        reg_rd(32'h0100_000A, "trig_status");
        buf_rd(0, 0, 1'b0, ramp_lo(t), "trig_b0c0w0");
        buf_rd(0, 2, 1'b1, 32'h0000_0002, "trig_b0c2w1");

        // Timeout with no trigger
        reg_wr(32'h5, "to_start", s);
        wait_idle("to", when);
        check("to_idle_cycle", 32'(when), 32'(s + 101));
        reg_rd(32'h0000_000C, "to_status");

        // Bus errors and START ignored during capture
        reg_wr(32'h1, "err_start", s);
        bus_err(1'b0, buf_adr(3, 1, 1'b0), "err_rd_capture");
        bus_err(1'b1, buf_adr(3, 1, 1'b0), "err_buf_wr");
        bus_err(1'b0, REG_ADR4, "err_reg4");
        reg_wr(32'h1, "restart_ignored", acc);
        wait_idle("err", when);
        check("err_done_cycle", 32'(when), 32'(s + 257));
        reg_rd(32'h0100_0002, "err_status");
        bus_err(1'b1, buf_adr(3, 1, 1'b0), "err_buf_wr_done");

        // Abort at beat 50, then START|ABORT collision
        reg_wr(32'h1, "ab_start", s);
        repeat (49) @(posedge aclk);
        reg_wr(32'h2, "ab_abort", acc);
        check("ab_abort_beat", 32'(acc - s - 1), 32'd50);
        reg_rd(32'h0032_0000, "ab_status");
        reg_wr(32'h3, "ab_collide", acc);
        reg_rd(32'h0032_0000, "ab_collide_status");
        check("ab_collide_busy", 32'(busy), 32'd0);

        // A held strobe gets exactly one termination
        begin
            exp_t e;
            e.is_err = 1'b0; e.chk_dat = 1'b1; e.dat = 32'h0032_0000; e.lat = 1;
            exp_q.push_back(e);
            name_q.push_back("hold_rd");
        end
        @(posedge aclk); #1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = REG_ADR; wb.wb_sel_i = 4'hF;
        issue_cyc = cyc_cnt;
        n_ack = 0;
        repeat (5) begin
            @(posedge aclk); #1;
            if (wb.wb_ack_o) n_ack++;
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        check("hold_single_ack", 32'(n_ack), 32'd1);

        // Reset in the middle of a capture
        reg_wr(32'h1, "rst_start", s);
        repeat (20) @(posedge aclk);
        @(posedge aclk); #1;
        check("mid_busy_before", 32'(busy), 32'd1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ack",  32'(wb.wb_ack_o), 32'd0);
        check("mid_rst_err",  32'(wb.wb_err_o), 32'd0);
        check("mid_rst_rty",  32'(wb.wb_rty_o), 32'd0);
        check("mid_rst_dat",  wb.wb_dat_o, 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        reg_rd(32'h0000_0000, "mid_rst_status");
        @(posedge aclk); #1;
        check("mid_rst_busy_after", 32'(busy), 32'd0);

        repeat (3) @(posedge aclk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
